// File: rtl/uart_rxd_pkg.sv
// Shared types and constants for the UART receive packing interface.
package uart_rxd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_e;

  localparam int ERR_PAR_BIT   = 0;
  localparam int ERR_FRAME_BIT = 1;
  localparam int ERR_OVR_BIT   = 2;

  function automatic int calc_lanes(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the extra pointer bit separates full from empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  // Fullness is taken from the pre-edge pointers, so a same-cycle pop never frees room for a write.
  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = LW'(wr_ptr - rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rxd_pack_if.sv
// UART receive interface: buffers characters in a FIFO and packs them into bus words,
// with partial-word timeout flush and sticky overrun/frame/parity reporting.
module uart_rxd_pack_if
  import uart_rxd_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int BUS_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst,
  input  logic                                            i_rxd_fifo_wr,
  input  logic [DATA_W+1:0]                               i_rxd_fifo_wdata,
  output logic                                            o_rxd_fifo_wfull,
  input  logic                                            i_pack_en,
  input  logic                                            i_rd,
  output logic                                            o_rvalid,
  output logic [BUS_W-1:0]                                o_rdata,
  output logic [$clog2(calc_lanes(BUS_W, DATA_W)+1)-1:0] o_rcount,
  output logic [$clog2(DEPTH+1)-1:0]                      o_level,
  output logic                                            o_busy,
  output logic [2:0]                                      o_error,
  input  logic                                            i_error_clr
);

  localparam int LANES = calc_lanes(BUS_W, DATA_W);
  localparam int CW    = $clog2(LANES + 1);
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  rx_state_e         state_q, state_d;
  logic [BUS_W-1:0]  word_q, word_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        err_q, err_d;
  logic              fifo_rd;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_rdata;
  logic              wr_accept;

  uart_sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .wr   (i_rxd_fifo_wr),
    .wdata(i_rxd_fifo_wdata[DATA_W-1:0]),
    .rd   (fifo_rd),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(o_level)
  );

  assign wr_accept = i_rxd_fifo_wr && !fifo_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Sets are applied after the clear so a same-cycle event is never lost.
  always_comb begin
    err_d = i_error_clr ? 3'b000 : err_q;
    if (i_rxd_fifo_wr && fifo_full)                 err_d[ERR_OVR_BIT]   = 1'b1;
    if (wr_accept && i_rxd_fifo_wdata[DATA_W+1])    err_d[ERR_FRAME_BIT] = 1'b1;
    if (wr_accept && i_rxd_fifo_wdata[DATA_W])      err_d[ERR_PAR_BIT]   = 1'b1;
  end

  // The pack mode is only consulted when leaving IDLE, so later i_pack_en changes cannot disturb a word.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    timer_d = timer_q;
    fifo_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          fifo_rd             = 1'b1;
          word_d              = '0;
          word_d[DATA_W-1:0]  = fifo_rdata;
          count_d             = CW'(1);
          state_d             = (i_pack_en && (LANES > 1)) ? COLLECT : HOLD;
        end
      end
      COLLECT: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          timer_d = '0;
          for (int k = 0; k < LANES; k++) begin
            if (count_q == CW'(k)) word_d[k*DATA_W +: DATA_W] = fifo_rdata;
          end
          count_d = count_q + CW'(1);
          if (count_d == CW'(LANES)) state_d = HOLD;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TLAST) state_d = HOLD;
          else                  timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if (i_rd) begin
          state_d = IDLE;
          word_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rvalid         = (state_q == HOLD);
  assign o_rdata          = o_rvalid ? word_q : '0;
  assign o_rcount         = o_rvalid ? count_q : '0;
  assign o_busy           = !fifo_empty || (state_q != IDLE);
  assign o_error          = err_q;
  assign o_rxd_fifo_wfull = fifo_full;

endmodule

// File: tb/tb_uart_rxd_pack_if.sv
// Self-checking bench for uart_rxd_pack_if: directed vector table, corner sequences, randomized model check.
module tb_uart_rxd_pack_if;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int BUS_W   = 32;
  localparam int TIMEOUT = 8;
  localparam int LANES   = BUS_W / DATA_W;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_rxd_fifo_wr;
  logic [DATA_W+1:0] i_rxd_fifo_wdata;
  logic              o_rxd_fifo_wfull;
  logic              i_pack_en;
  logic              i_rd;
  logic              o_rvalid;
  logic [BUS_W-1:0]  o_rdata;
  logic [2:0]        o_rcount;
  logic [4:0]        o_level;
  logic              o_busy;
  logic [2:0]        o_error;
  logic              i_error_clr;

  int checks = 0;
  int errors = 0;

  uart_rxd_pack_if #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .BUS_W  (BUS_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_rxd_fifo_wr   (i_rxd_fifo_wr),
    .i_rxd_fifo_wdata(i_rxd_fifo_wdata),
    .o_rxd_fifo_wfull(o_rxd_fifo_wfull),
    .i_pack_en       (i_pack_en),
    .i_rd            (i_rd),
    .o_rvalid        (o_rvalid),
    .o_rdata         (o_rdata),
    .o_rcount        (o_rcount),
    .o_level         (o_level),
    .o_busy          (o_busy),
    .o_error         (o_error),
    .i_error_clr     (i_error_clr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr;
    logic [9:0]  wdata;
    logic        pack;
    logic        rd;
    logic        clr;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_count;
    logic [4:0]  exp_level;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[14];

  // Reference model: plain queues for the FIFO and the word being assembled.
  logic [DATA_W-1:0] m_fifo[$];
  logic [DATA_W-1:0] m_chars[$];
  bit                m_coll;
  bit                m_valid;
  int                m_idle;
  logic [2:0]        m_err;

  task automatic apply_stimulus(input logic wr, input logic [9:0] wdata, input logic pack,
                                input logic rd, input logic clr);
    i_rxd_fifo_wr    = wr;
    i_rxd_fifo_wdata = wdata;
    i_pack_en        = pack;
    i_rd             = rd;
    i_error_clr      = clr;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_chars.delete();
    m_coll  = 0;
    m_valid = 0;
    m_idle  = 0;
    m_err   = '0;
  endtask

  task automatic model_step(input logic wr, input logic [9:0] wdata, input logic pack,
                            input logic rd, input logic clr);
    bit                full0  = (m_fifo.size() == DEPTH);
    bit                empty0 = (m_fifo.size() == 0);
    bit                popped = 0;
    logic [DATA_W-1:0] head   = '0;
    if (!empty0) head = m_fifo[0];
    if (m_valid) begin
      if (rd) begin
        m_valid = 0;
        m_chars.delete();
      end
    end else if (!m_coll) begin
      if (!empty0) begin
        popped = 1;
        m_chars.delete();
        m_chars.push_back(head);
        if (pack && LANES > 1) begin
          m_coll = 1;
          m_idle = 0;
        end else m_valid = 1;
      end
    end else begin
      if (!empty0) begin
        popped = 1;
        m_chars.push_back(head);
        m_idle = 0;
        if (m_chars.size() == LANES) begin
          m_coll  = 0;
          m_valid = 1;
        end
      end else if (TIMEOUT != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_coll  = 0;
          m_valid = 1;
        end
      end
    end
    if (popped) void'(m_fifo.pop_front());
    if (clr) m_err = '0;
    if (wr) begin
      if (full0) m_err[2] = 1'b1;
      else begin
        m_fifo.push_back(wdata[DATA_W-1:0]);
        if (wdata[9]) m_err[1] = 1'b1;
        if (wdata[8]) m_err[0] = 1'b1;
      end
    end
  endtask

  task automatic check_model(input int cyc);
    logic [31:0] exp_word = '0;
    if (m_valid) begin
      foreach (m_chars[k]) exp_word[k*DATA_W +: DATA_W] = m_chars[k];
    end
    check_output($sformatf("rnd%0d_valid", cyc), 32'(o_rvalid), 32'(m_valid));
    check_output($sformatf("rnd%0d_rdata", cyc), o_rdata, exp_word);
    check_output($sformatf("rnd%0d_rcount", cyc), 32'(o_rcount), m_valid ? m_chars.size() : 0);
    check_output($sformatf("rnd%0d_level", cyc), 32'(o_level), m_fifo.size());
    check_output($sformatf("rnd%0d_full", cyc), 32'(o_rxd_fifo_wfull), 32'(m_fifo.size() == DEPTH));
    check_output($sformatf("rnd%0d_busy", cyc), 32'(o_busy),
                 32'(m_fifo.size() > 0 || m_coll || m_valid));
    check_output($sformatf("rnd%0d_error", cyc), 32'(o_error), 32'(m_err));
  endtask

  initial begin
    logic [9:0] wd;
    logic       wr, rd, clr, pk;

    i_rst = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    check_output("reset_valid", 32'(o_rvalid), 0);
    check_output("reset_rdata", o_rdata, 0);
    check_output("reset_rcount", 32'(o_rcount), 0);
    check_output("reset_level", 32'(o_level), 0);
    check_output("reset_full", 32'(o_rxd_fifo_wfull), 0);
    check_output("reset_busy", 32'(o_busy), 0);
    check_output("reset_error", 32'(o_error), 0);

    // Byte mode 0x93, packed 0x11..0x44, then mode latched only in IDLE.
    vecs[0]  = '{1'b1, 10'h093, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[1]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000093, 3'd1, 5'd0, 1'b1};
    vecs[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000093, 3'd1, 5'd0, 1'b1};
    vecs[3]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[5]  = '{1'b1, 10'h022, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[6]  = '{1'b1, 10'h033, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[7]  = '{1'b1, 10'h044, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[8]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4, 5'd0, 1'b1};
    vecs[9]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 5'd0, 1'b0};
    vecs[10] = '{1'b1, 10'h055, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[11] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd0, 1'b1};
    vecs[12] = '{1'b1, 10'h066, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd1, 1'b1};
    vecs[13] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 5'd0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].wdata, vecs[i].pack, vecs[i].rd, vecs[i].clr);
      tick();
      check_output($sformatf("vec%0d_valid", i), 32'(o_rvalid), 32'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d_rcount", i), 32'(o_rcount), 32'(vecs[i].exp_count));
      check_output($sformatf("vec%0d_level", i), 32'(o_level), 32'(vecs[i].exp_level));
      check_output($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vecs[i].exp_busy));
    end

    // Partial word flushed after TIMEOUT empty cycles.
    do_reset();
    apply_stimulus(1'b1, 10'h0AA, 1'b1, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 10'h0BB, 1'b1, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check_output($sformatf("tmo_wait%0d_valid", i), 32'(o_rvalid), 0);
    end
    tick();
    check_output("tmo_valid", 32'(o_rvalid), 1);
    check_output("tmo_rdata", o_rdata, 32'h0000BBAA);
    check_output("tmo_rcount", 32'(o_rcount), 2);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    check_output("tmo_read_valid", 32'(o_rvalid), 0);
    check_output("tmo_read_busy", 32'(o_busy), 0);

    // Overflow: packer takes 4, FIFO takes 16, the 21st write is the first refused.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      apply_stimulus(1'b1, 10'(i), 1'b1, 1'b0, 1'b0);
      tick();
      check_output($sformatf("ovr_w%0d_err", i), 32'(o_error), (i >= 20) ? 32'h4 : 32'h0);
    end
    check_output("ovr_full", 32'(o_rxd_fifo_wfull), 1);
    check_output("ovr_level", 32'(o_level), 16);
    check_output("ovr_rdata", o_rdata, 32'h03020100);
    apply_stimulus(1'b1, 10'h0EE, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("ovr_set_wins", 32'(o_error), 32'h4);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    check_output("ovr_clr", 32'(o_error), 0);

    // Frame and parity flags are sticky and stripped from the data.
    do_reset();
    apply_stimulus(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("ferr_error", 32'(o_error), 32'h3);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("ferr_clr", 32'(o_error), 0);
    check_output("ferr_rdata", o_rdata, 32'h000000FF);
    check_output("ferr_rcount", 32'(o_rcount), 1);
    apply_stimulus(1'b1, 10'h212, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("ferr_set_vs_clr", 32'(o_error), 32'h2);

    // Randomized traffic against the queue model, including occasional mid-word resets.
    do_reset();
    model_reset();
    pk = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      wr = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) pk = ~pk;
      wd = 10'($urandom_range(0, 255));
      wd[9] = ($urandom_range(0, 15) == 0);
      wd[8] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        model_reset();
      end else begin
        apply_stimulus(wr, wd, pk, rd, clr);
        model_step(wr, wd, pk, rd, clr);
        tick();
      end
      check_model(cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rxd_pack_if.md
Name: uart_rxd_pack_if

Overview:
Single-clock UART receive interface. Buffers received characters (data plus parity/frame error flags) from the UART RX core in a synchronous FIFO and packs them into bus-width words for the CPU read port. Adds the following to the existing receive path:
- selectable byte or packed mode
- partial-word timeout flush
- sticky overrun/parity/frame error reporting
Sits between uart_rx core and the register/bus slave.

Parameters:
DATA_W, 8, character data width
DEPTH, 16, FIFO entries (power of 2, >=2)
BUS_W, 32, read word width; LANES=BUS_W/DATA_W (integer, >=1)
TIMEOUT, 255, idle cycles before partial word is flushed; 0 disables flush

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_rxd_fifo_wr  in  1  write strobe from RX core
i_rxd_fifo_wdata  in  DATA_W+2  bit DATA_W+1 frame err, bit DATA_W parity err, [DATA_W-1:0] data
o_rxd_fifo_wfull  out  1  FIFO full
i_pack_en  in  1  1 = pack LANES chars per word, 0 = one char per word
i_rd  in  1  consume current output word
o_rvalid  out  1  output word valid
o_rdata  out  BUS_W  output word, char k in lane k (little-endian)
o_rcount  out  $clog2(LANES+1)  valid chars in o_rdata
o_level  out  $clog2(DEPTH+1)  FIFO occupancy
o_busy  out  1  FIFO non-empty OR partial word held OR o_rvalid
o_error  out  3  sticky {overrun, frame, parity}
i_error_clr  in  1  clear all sticky errors

Behaviour:
- Clocking/reset: one clock i_clk; i_rst synchronous active-high. Reset clears FIFO pointers, packer, timer, sticky errors. All outputs are 0 after reset, o_rxd_fifo_wfull included.
- Write: accepted when i_rxd_fifo_wr=1 and FIFO not full at the edge. Fullness is judged before any same-cycle pop.
- Write to full FIFO: character dropped; o_error[2] set.
- Sticky errors: an accepted character with bit DATA_W+1 / DATA_W set sets o_error[1] / o_error[0]. i_error_clr clears all three. If a set and a clear occur in the same cycle, the set wins.
- FIFO: first-word-fall-through. At most one pop per cycle. o_level is updated on every edge (write and pop in the same cycle leave it unchanged).
- FSM states IDLE, COLLECT, HOLD.
  - IDLE: the mode is latched from i_pack_en only here. If FIFO is non-empty, pop into lane 0 with count=1. Byte mode (or LANES=1) goes to HOLD; packed mode goes to COLLECT.
  - COLLECT: pop into lane[count] whenever FIFO is non-empty. Go to HOLD when count reaches LANES. The timer counts cycles with FIFO empty and is reset by every pop. Timer==TIMEOUT (TIMEOUT!=0) flushes the partial word to HOLD. i_pack_en changes are ignored until the next IDLE.
  - HOLD: o_rvalid=1; o_rdata/o_rcount are stable, unused upper lanes are 0. On i_rd=1 go to IDLE; o_rvalid drops at that edge. i_rd with o_rvalid=0 is ignored.
- Latency:
  - Byte mode: char written at edge N gives o_rvalid=1 after edge N+1.
  - Packed mode: back-to-back writes at edges N..N+LANES-1 give o_rvalid=1 after edge N+LANES.
  - Next word after i_rd: earliest o_rvalid 2 edges later (IDLE pop, then HOLD).
- Error flags are not carried into o_rdata; they are only reflected in o_error.
- FIFO pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset mid-word discards the partial word and the FIFO contents.

Decomposition:
- Package uart_rxd_pkg:
  - state enum typedef (IDLE/COLLECT/HOLD)
  - bit-index constants ERR_FRAME_BIT, ERR_PAR_BIT, ERR_OVR_BIT
  - helper function computing LANES
- Sub-module uart_sync_fifo: parametrised width/depth, FWFT, with full/empty/level outputs.

Test Plan:
- Reset then idle -> all outputs 0, o_busy=0.
- Byte mode, write 0x93 -> o_rvalid after 2 edges; o_rdata=0x00000093, o_rcount=1; i_rd -> o_rvalid=0, o_busy=0.
- Packed mode, writes 0x11,0x22,0x33,0x44 back-to-back -> o_rdata=0x44332211, o_rcount=4, after 4 edges past the first write.
- Packed mode, TIMEOUT=8, write 0xAA,0xBB then idle -> after 8 empty cycles o_rdata=0x0000BBAA, o_rcount=2.
- DEPTH=16, no i_rd, 22 writes -> FIFO and packer fill; o_rxd_fifo_wfull=1, o_level=16; o_error[2]=1 on the first refused write. i_error_clr asserted in the same cycle as a further refused write -> o_error[2] stays 1.
- Write with frame bit set (data 0x3FF) -> o_error=3'b011. i_error_clr -> o_error=0. Data still delivered as 0xFF.
